// File: rtl/combat_pkg.sv
// Shared types and helpers for the combat arbiter: FSM states, damage command, distance.
package combat_pkg;

  localparam int unsigned PKG_N_ENEMY   = 4;
  localparam int unsigned PKG_POS_WIDTH = 10;
  localparam int unsigned IDX_W         = $clog2(PKG_N_ENEMY);
  localparam int unsigned DIST_W        = PKG_POS_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_EGRANT = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             to_player;
    logic [IDX_W-1:0] idx;
  } dmg_cmd_t;

  // |dx|+|dy| with one extra bit so the sum never wraps.
  function automatic logic [DIST_W-1:0] manhattan_dist(
    input logic [PKG_POS_WIDTH-1:0] x0,
    input logic [PKG_POS_WIDTH-1:0] y0,
    input logic [PKG_POS_WIDTH-1:0] x1,
    input logic [PKG_POS_WIDTH-1:0] y1
  );
    logic [PKG_POS_WIDTH-1:0] dx;
    logic [PKG_POS_WIDTH-1:0] dy;
    dx = (x0 >= x1) ? (x0 - x1) : (x1 - x0);
    dy = (y0 >= y1) ? (y0 - y1) : (y1 - y0);
    return DIST_W'(dx) + DIST_W'(dy);
  endfunction

endpackage

// File: rtl/combat_arbiter_rr_picker.sv
// Combinational round-robin search over pending requests, starting just after ptr.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int off = N; off >= 1; off--) begin
      if (i_req[IW'((32'(i_ptr) + 32'(off)) % N)]) begin
        o_any = 1'b1;
        o_idx = IW'((32'(i_ptr) + 32'(off)) % N);
      end
    end
  end

endmodule

// File: rtl/combat_arbiter.sv
// Serialises player-attack scans and enemy attacks into single "minus 1" damage commands.
// The command struct and distance helper are sized by the package defaults.
module combat_arbiter
  import combat_pkg::*;
#(
  parameter int unsigned N_ENEMY      = PKG_N_ENEMY,
  parameter int unsigned POS_WIDTH    = PKG_POS_WIDTH,
  parameter int unsigned HP_WIDTH     = 2,
  parameter int unsigned ATK_RANGE    = 32,
  parameter int unsigned INVULN_TICKS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  input  logic                           i_tick,
  input  logic                           i_player_atk,
  input  logic                           i_player_shield,
  input  logic [POS_WIDTH-1:0]           i_player_x,
  input  logic [POS_WIDTH-1:0]           i_player_y,
  input  logic [N_ENEMY*POS_WIDTH-1:0]   i_enemy_x,
  input  logic [N_ENEMY*POS_WIDTH-1:0]   i_enemy_y,
  input  logic [N_ENEMY*HP_WIDTH-1:0]    i_enemy_hp,
  input  logic [N_ENEMY-1:0]             i_enemy_atk,
  output logic                           o_dmg_valid,
  output logic                           o_dmg_to_player,
  output logic [$clog2(N_ENEMY)-1:0]     o_dmg_idx,
  output logic                           o_blocked,
  output logic                           o_invuln,
  output logic                           o_busy
);

  localparam int unsigned IW    = $clog2(N_ENEMY);
  localparam int unsigned CNT_W = (INVULN_TICKS < 1) ? 1 : $clog2(INVULN_TICKS + 1);

  state_t               r_state, w_state_nxt;
  logic                 r_pend_p;
  logic [N_ENEMY-1:0]   r_pend_e;
  logic [IW-1:0]        r_ptr, w_ptr_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [CNT_W-1:0]     r_inv_cnt, w_inv_cnt_nxt;
  dmg_cmd_t             r_cmd, w_cmd_nxt;
  logic                 r_blocked, w_blocked_nxt;
  logic                 r_invuln;
  logic                 r_busy;

  logic                 w_pend_p_set;
  logic                 w_pend_p_clr;
  logic [N_ENEMY-1:0]   w_pend_e_clr;
  logic [N_ENEMY-1:0]   w_alive;
  logic                 w_inv_load;
  logic                 w_pick_any;
  logic [IW-1:0]        w_pick_idx;
  logic [POS_WIDTH-1:0] w_ex [N_ENEMY];
  logic [POS_WIDTH-1:0] w_ey [N_ENEMY];
  logic [POS_WIDTH:0]   w_dist;
  logic                 w_in_range;

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_unpack
    assign w_ex[g]    = i_enemy_x[g*POS_WIDTH +: POS_WIDTH];
    assign w_ey[g]    = i_enemy_y[g*POS_WIDTH +: POS_WIDTH];
    assign w_alive[g] = |i_enemy_hp[g*HP_WIDTH +: HP_WIDTH];
  end

  assign w_dist       = manhattan_dist(i_player_x, i_player_y, w_ex[r_idx], w_ey[r_idx]);
  assign w_in_range   = (32'(w_dist) <= ATK_RANGE);
  // A second player attack is dropped while one is pending or a scan is running.
  assign w_pend_p_set = i_player_atk & ~r_pend_p & (r_state != ST_SCAN);

  rr_picker #(
    .N  (N_ENEMY),
    .IW (IW)
  ) u_rr_picker (
    .i_req (r_pend_e),
    .i_ptr (r_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  // Next-state and registered-output decisions; disable overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_cmd_nxt     = '0;
    w_blocked_nxt = 1'b0;
    w_inv_load    = 1'b0;
    w_pend_p_clr  = 1'b0;
    w_pend_e_clr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_p) begin
          w_pend_p_clr = 1'b1;
          w_idx_nxt    = '0;
          w_state_nxt  = ST_SCAN;
        end else if (w_pick_any) begin
          w_pend_e_clr[w_pick_idx] = 1'b1;
          w_ptr_nxt                = w_pick_idx;
          w_state_nxt              = ST_EGRANT;
        end
      end
      ST_SCAN: begin
        if (w_alive[r_idx] && w_in_range) begin
          w_cmd_nxt.valid     = 1'b1;
          w_cmd_nxt.to_player = 1'b0;
          w_cmd_nxt.idx       = r_idx;
        end
        if (r_idx == IW'(N_ENEMY - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      ST_EGRANT: begin
        w_state_nxt = ST_IDLE;
        if (i_player_shield) begin
          w_blocked_nxt = 1'b1;
        end else if (r_inv_cnt == '0) begin
          w_cmd_nxt.valid     = 1'b1;
          w_cmd_nxt.to_player = 1'b1;
          w_cmd_nxt.idx       = r_ptr;
          w_inv_load          = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!i_enable) begin
      w_state_nxt   = ST_IDLE;
      w_ptr_nxt     = r_ptr;
      w_cmd_nxt     = '0;
      w_blocked_nxt = 1'b0;
      w_inv_load    = 1'b0;
      w_pend_p_clr  = 1'b0;
      w_pend_e_clr  = '0;
    end
  end

  // Invulnerability counter: load beats tick, tick saturates at zero.
  always_comb begin
    w_inv_cnt_nxt = r_inv_cnt;
    if (!i_enable) begin
      w_inv_cnt_nxt = '0;
    end else if (w_inv_load) begin
      w_inv_cnt_nxt = CNT_W'(INVULN_TICKS);
    end else if (i_tick && (r_inv_cnt != '0)) begin
      w_inv_cnt_nxt = r_inv_cnt - CNT_W'(1);
    end
  end

  // State, pending latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pend_p  <= 1'b0;
      r_pend_e  <= '0;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_inv_cnt <= '0;
      r_cmd     <= '0;
      r_blocked <= 1'b0;
      r_invuln  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_inv_cnt <= w_inv_cnt_nxt;
      r_cmd     <= w_cmd_nxt;
      r_blocked <= w_blocked_nxt;
      r_invuln  <= (w_inv_cnt_nxt != '0);
      r_busy    <= (w_state_nxt == ST_SCAN);
      if (!i_enable) begin
        r_pend_p <= 1'b0;
        r_pend_e <= '0;
      end else begin
        r_pend_p <= (r_pend_p & ~w_pend_p_clr) | w_pend_p_set;
        r_pend_e <= (r_pend_e & ~w_pend_e_clr) | (i_enemy_atk & w_alive);
      end
    end
  end

  assign o_dmg_valid     = r_cmd.valid;
  assign o_dmg_to_player = r_cmd.to_player;
  assign o_dmg_idx       = r_cmd.idx;
  assign o_blocked       = r_blocked;
  assign o_invuln        = r_invuln;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_combat_arbiter.sv
// Scoreboard bench for combat_arbiter; a second instance runs with zero invulnerability.
module tb_combat_arbiter;

  localparam int N  = 4;
  localparam int PW = 10;
  localparam int HW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            tick = 1'b0;
  logic            p_atk = 1'b0;
  logic            shield = 1'b0;
  logic [PW-1:0]   px = '0;
  logic [PW-1:0]   py = '0;
  logic [N*PW-1:0] ex = '0;
  logic [N*PW-1:0] ey = '0;
  logic [N*HW-1:0] ehp = '0;
  logic [N-1:0]    e_atk = '0;

  logic a_valid, a_tp, a_blocked, a_invuln, a_busy;
  logic [1:0] a_idx;
  logic b_valid, b_tp, b_blocked, b_invuln, b_busy;
  logic [1:0] b_idx;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  logic sel_b = 1'b0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  combat_arbiter u_dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_tick(tick), .i_player_atk(p_atk),
    .i_player_shield(shield), .i_player_x(px), .i_player_y(py),
    .i_enemy_x(ex), .i_enemy_y(ey), .i_enemy_hp(ehp), .i_enemy_atk(e_atk),
    .o_dmg_valid(a_valid), .o_dmg_to_player(a_tp), .o_dmg_idx(a_idx),
    .o_blocked(a_blocked), .o_invuln(a_invuln), .o_busy(a_busy)
  );

  combat_arbiter #(.INVULN_TICKS(0)) u_dut_noinv (
    .clk(clk), .rst(rst), .i_enable(en), .i_tick(tick), .i_player_atk(p_atk),
    .i_player_shield(shield), .i_player_x(px), .i_player_y(py),
    .i_enemy_x(ex), .i_enemy_y(ey), .i_enemy_hp(ehp), .i_enemy_atk(e_atk),
    .o_dmg_valid(b_valid), .o_dmg_to_player(b_tp), .o_dmg_idx(b_idx),
    .o_blocked(b_blocked), .o_invuln(b_invuln), .o_busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event encoding {blocked, valid, to_player, idx}
  function automatic logic [4:0] ev_hit(input int k);
    return {1'b0, 1'b1, 1'b0, 2'(k)};
  endfunction
  function automatic logic [4:0] ev_pl(input int k);
    return {1'b0, 1'b1, 1'b1, 2'(k)};
  endfunction
  localparam logic [4:0] EV_BLK = 5'b10000;

  // Monitor: pop the scoreboard on every command/blocked pulse, count busy cycles.
  always @(negedge clk) begin
    logic v, b, tp, bz;
    logic [1:0] ix;
    logic [4:0] ev;
    if (sel_b) {v, b, tp, ix, bz} = {b_valid, b_blocked, b_tp, b_idx, b_busy};
    else       {v, b, tp, ix, bz} = {a_valid, a_blocked, a_tp, a_idx, a_busy};
    if (bz) busy_cnt++;
    if (!rst && (v || b)) begin
      ev = {b, v, b ? 1'b0 : tp, b ? 2'b00 : ix};
      if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 32'(0));
      else                   check("event", 32'(ev), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_enemy(input int k, input int x, input int y, input int hp);
    ex[k*PW +: PW]  = PW'(x);
    ey[k*PW +: PW]  = PW'(y);
    ehp[k*HW +: HW] = HW'(hp);
  endtask

  task automatic player_pulse();
    p_atk = 1'b1;
    step();
    p_atk = 1'b0;
  endtask

  task automatic enemy_pulse(input logic [N-1:0] m);
    e_atk = m;
    step();
    e_atk = '0;
  endtask

  task automatic drain(input string tag);
    step(14);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    busy_cnt = 0;
  endtask

  initial begin
    px = PW'(100);
    py = PW'(100);
    set_enemy(0, 110, 120, 1);
    set_enemy(1, 200, 200, 3);
    set_enemy(2, 100, 131, 2);
    set_enemy(3, 90, 95, 0);
    #3;
    check("reset_outputs_a", 32'({a_valid, a_tp, a_idx, a_blocked, a_invuln, a_busy}), 32'(0));
    check("reset_outputs_b", 32'({b_valid, b_tp, b_idx, b_blocked, b_invuln, b_busy}), 32'(0));
    step();
    rst = 1'b0;
    en  = 1'b1;
    step();

    // Scan: dist 30 hits, 200 misses, 31 hits, dead enemy ignored.
    busy_cnt = 0;
    exp_q.push_back(ev_hit(0));
    exp_q.push_back(ev_hit(2));
    player_pulse();
    drain("scan1");
    check("scan1_busy_cycles", 32'(busy_cnt), 32'(4));

    // Dist 33 is out of range.
    set_enemy(2, 100, 133, 2);
    busy_cnt = 0;
    exp_q.push_back(ev_hit(0));
    player_pulse();
    drain("scan_dist33");
    check("scan2_busy_cycles", 32'(busy_cnt), 32'(4));

    // Dist 32 sits exactly on the inclusive limit.
    set_enemy(2, 100, 132, 2);
    exp_q.push_back(ev_hit(0));
    exp_q.push_back(ev_hit(2));
    player_pulse();
    drain("scan_dist32");

    // Round robin from ptr=0 on the zero-invulnerability instance.
    do_reset();
    sel_b = 1'b1;
    set_enemy(3, 90, 95, 1);
    exp_q.push_back(ev_pl(1));
    exp_q.push_back(ev_pl(2));
    exp_q.push_back(ev_pl(3));
    exp_q.push_back(ev_pl(0));
    enemy_pulse(4'b1111);
    drain("round_robin");
    sel_b = 1'b0;

    // Shield absorbs, no invulnerability.
    do_reset();
    shield = 1'b1;
    exp_q.push_back(EV_BLK);
    enemy_pulse(4'b0100);
    drain("shield");
    check("shield_invuln", 32'(a_invuln), 32'(0));
    shield = 1'b0;

    // Hit, then invulnerability window.
    exp_q.push_back(ev_pl(1));
    enemy_pulse(4'b0010);
    drain("hit_e1");
    check("invuln_after_hit", 32'(a_invuln), 32'(1));
    enemy_pulse(4'b1000);
    drain("discard_e3");
    for (int t = 0; t < 2; t++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    check("invuln_after_2_ticks", 32'(a_invuln), 32'(1));
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("invuln_after_3_ticks", 32'(a_invuln), 32'(0));
    exp_q.push_back(ev_pl(0));
    enemy_pulse(4'b0001);
    drain("hit_after_invuln");
    check("invuln_reloaded", 32'(a_invuln), 32'(1));

    // Player attack wins over a simultaneous enemy attack; repeat attack during scan dropped.
    do_reset();
    set_enemy(2, 100, 131, 2);
    set_enemy(3, 90, 95, 0);
    exp_q.push_back(ev_hit(0));
    exp_q.push_back(ev_hit(2));
    exp_q.push_back(ev_pl(1));
    p_atk = 1'b1;
    e_atk = 4'b0010;
    step();
    p_atk = 1'b0;
    e_atk = '0;
    step();
    check("priority_in_scan", 32'(a_busy), 32'(1));
    player_pulse();
    drain("priority");
    check("priority_busy_cycles", 32'(busy_cnt), 32'(4));

    // Disable mid-scan with enemy requests pending.
    do_reset();
    for (int k = 0; k < N; k++) set_enemy(k, 100, 100, 1);
    exp_q.push_back(ev_hit(0));
    player_pulse();
    step();
    e_atk = 4'b0101;
    step();
    e_atk = '0;
    en    = 1'b0;
    step();
    check("disable_busy", 32'(a_busy), 32'(0));
    check("disable_valid", 32'(a_valid), 32'(0));
    step();
    en = 1'b1;
    drain("disable");
    check("disable_busy_cycles", 32'(busy_cnt), 32'(2));

    // Asynchronous reset in the middle of a scan.
    player_pulse();
    step();
    check("pre_reset_busy", 32'(a_busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_a", 32'({a_valid, a_tp, a_idx, a_blocked, a_invuln, a_busy}), 32'(0));
    check("async_reset_b", 32'({b_valid, b_tp, b_idx, b_blocked, b_invuln, b_busy}), 32'(0));
    step();
    rst = 1'b0;
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
